// File: rtl/bcd_serial_adder_if.sv
// Start/Done handshake bundle for the digit-serial BCD adder/subtractor.
// Operands and result are packed BCD, DIGITS digits wide.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         Start;
  logic         Sub;
  logic         Carry_In;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] S;
  logic         Carry_Out;
  logic         Invalid;

  modport master (
    output Start, Sub, Carry_In, A, B,
    input  Busy, Done, S, Carry_Out, Invalid
  );

  modport slave (
    input  Start, Sub, Carry_In, A, B,
    output Busy, Done, S, Carry_Out, Invalid
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional input digit check: define BCD_SERIAL_INVALID_CHECK_EN.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input logic              Clk,
  input logic              Rst,
  bcd_serial_adder_if.slave io
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nxt;

  logic [W-1:0]  a_sh, b_sh, s_r, s_nx;
  logic [IW-1:0] idx;
  logic          carry, sub_r, co_r;
  logic [3:0]    a_d, b_d, b_c, dig;
  logic [4:0]    z;
  logic          c_nx, last, load;

  always_comb begin
    a_d  = a_sh[3:0];
    b_d  = b_sh[3:0];
    b_c  = sub_r ? (4'd9 - b_d) : b_d;
    z    = {1'b0, a_d} + {1'b0, b_c} + {4'b0, carry};
    c_nx = (z > 5'd9);
    dig  = c_nx ? (z[3:0] + 4'd6) : z[3:0];
    last = (idx == IW'(DIGITS - 1));
    load = io.Start && (state != RUN);
  end

  // New digit enters at the top; after DIGITS steps digit 0 is at [3:0].
  generate
    if (DIGITS == 1) begin : g_one
      assign s_nx = dig;
    end else begin : g_many
      assign s_nx = {dig, s_r[W-1:4]};
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (io.Start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = io.Start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_r   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      co_r  <= 1'b0;
    end else if (load) begin
      a_sh  <= io.A;
      b_sh  <= io.B;
      s_r   <= '0;
      idx   <= '0;
      carry <= io.Carry_In;
      sub_r <= io.Sub;
      co_r  <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      s_r   <= s_nx;
      idx   <= idx + 1'b1;
      carry <= c_nx;
      if (last) co_r <= c_nx;
    end
  end

`ifdef BCD_SERIAL_INVALID_CHECK_EN
  logic inv_r;

  // Raw operand digits are checked, never the complemented one.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      inv_r <= 1'b0;
    else if (load)
      inv_r <= 1'b0;
    else if (state == RUN)
      inv_r <= inv_r | (a_d > 4'd9) | (b_d > 4'd9);
  end

  assign io.Invalid = inv_r;
`else
  assign io.Invalid = 1'b0;
`endif

  assign io.Busy      = (state == RUN);
  assign io.Done      = (state == DONE);
  assign io.S         = s_r;
  assign io.Carry_Out = co_r;
endmodule
